// File: rtl/odd_parity_frame_rx.sv
// Purpose : bit-serial receiver for start/data/odd-parity/stop frames with word-level output and error counter.
// Latency : out_valid rises on the clock edge after the stop-bit strobe is sampled.
// Backpr. : word is held until out_valid&out_ready; line strobes arriving meanwhile are dropped.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   ser_in, ser_valid  serial line bit and its per-bit strobe (gaps allowed)
//   clear_cnt          synchronous clear of err_count (wins over increment)
//   out_ready          consumer accepts the presented word
//   out_valid          data_out/par_err/frame_err are valid
//   data_out           received data word (LSB received first)
//   par_err            data+parity contained an even number of ones
//   frame_err          stop bit sampled as 0
//   err_count          saturating count of frames with par_err|frame_err
//   busy               receiver is in any state other than IDLE (registered)
module odd_parity_frame_rx #(
    parameter int DATA_W    = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ser_in,
    input  logic                 ser_valid,
    input  logic                 clear_cnt,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    data_out,
    output logic                 par_err,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam int                   CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_par_acc;
    logic [DATA_W-1:0]      r_data_out;
    logic                   r_par_err;
    logic                   r_frame_err;
    logic                   r_out_valid;
    logic [ERR_CNT_W-1:0]   r_err_count;
    logic                   r_busy;

    logic                   w_start;
    logic                   w_data_bit;
    logic                   w_par_bit;
    logic                   w_stop_bit;
    logic                   w_stop_err;

    assign w_start    = (r_state == S_IDLE)   && ser_valid && !ser_in;
    assign w_data_bit = (r_state == S_DATA)   && ser_valid;
    assign w_par_bit  = (r_state == S_PARITY) && ser_valid;
    assign w_stop_bit = (r_state == S_STOP)   && ser_valid;
    // par_acc already covers data and parity bits; odd total means a good frame.
    assign w_stop_err = ~r_par_acc | ~ser_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_DATA;
            S_DATA:   if (w_data_bit && (r_bit_cnt == LAST_BIT)) w_next = S_PARITY;
            S_PARITY: if (w_par_bit) w_next = S_STOP;
            S_STOP:   if (w_stop_bit) w_next = S_HOLD;
            // out_valid is always 1 in HOLD, so out_ready alone completes the handshake.
            S_HOLD:   if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_data_out  <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_out_valid <= 1'b0;
            r_err_count <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_cnt <= '0;
                r_par_acc <= 1'b0;
            end

            if (w_data_bit) begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (r_bit_cnt == CNT_W'(i)) begin
                        r_shift[i] <= ser_in;
                    end
                end
                r_par_acc <= r_par_acc ^ ser_in;
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end

            if (w_par_bit) begin
                r_par_acc <= r_par_acc ^ ser_in;
            end

            if (w_stop_bit) begin
                r_data_out  <= r_shift;
                r_par_err   <= ~r_par_acc;
                r_frame_err <= ~ser_in;
                r_out_valid <= 1'b1;
            end else if ((r_state == S_HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (clear_cnt) begin
                r_err_count <= '0;
            end else if (w_stop_bit && w_stop_err && (r_err_count != ERR_MAX)) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end

            // Registered copy of the next state keeps busy aligned with state
            // without a combinational path from inputs to the port.
            r_busy <= (w_next != S_IDLE);
        end
    end

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign par_err   = r_par_err;
    assign frame_err = r_frame_err;
    assign err_count = r_err_count;
    assign busy      = r_busy;

endmodule
